// File: rtl/vertex_fetch_if.sv
// vertex_fetch_if
//   Bundles the two handshakes of the vertex fetcher.
//   - Avalon-MM read master toward SDRAM: m_address, m_read, m_waitrequest,
//     m_readdata, m_readdatavalid.
//   - Assembled-vertex stream toward the transform stage: vtx_data, vtx_valid,
//     vtx_ready.
//   Modports:
//     master : the fetcher side (drives the read request and the vertex stream)
//     slave  : the memory / downstream side
interface vertex_fetch_if #(
  parameter int ADDR_W = 26
);
  logic [ADDR_W-1:0] m_address;
  logic              m_read;
  logic              m_waitrequest;
  logic [31:0]       m_readdata;
  logic              m_readdatavalid;

  logic [95:0]       vtx_data;
  logic              vtx_valid;
  logic              vtx_ready;

  modport master (
    output m_address,
    output m_read,
    input  m_waitrequest,
    input  m_readdata,
    input  m_readdatavalid,
    output vtx_data,
    output vtx_valid,
    input  vtx_ready
  );

  modport slave (
    input  m_address,
    input  m_read,
    output m_waitrequest,
    output m_readdata,
    output m_readdatavalid,
    input  vtx_data,
    input  vtx_valid,
    output vtx_ready
  );
endinterface

// File: rtl/vertex_fetch.sv
// vertex_fetch
//   Fetches a vertex buffer from SDRAM when a render is kicked and streams
//   assembled {z,y,x} vertices (96 bits) through a small FIFO.
//   Buffer layout: word0 = vertex count N, vertex i at words 1+3i..3+3i (x,y,z),
//   word k at byte address base + 4k (wrapping at 2^ADDR_W).
// Ports
//   clk                 system clock
//   reset_n             asynchronous active-low reset
//   start               do_render level; a rising edge in IDLE starts a frame
//   vertex_buffer_base  byte base of the buffer, sampled when a start is accepted
//   render_done         one-cycle pulse once the last vertex has left the FIFO
//   busy                high from the accepted start through render_done
//   bus (master)        Avalon read master + vertex valid/ready stream
//
// State table
//   state   | meaning
//   S_IDLE  | waiting for a start edge
//   S_RDCNT | count word requested, waiting for its data
//   S_FETCH | reading x,y,z of vertex r_widx and pushing the assembled vertex
//   S_DRAIN | all reads done; wait for FIFO empty, then pulse render_done
module vertex_fetch #(
  parameter int ADDR_W     = 26,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] vertex_buffer_base,
  output logic              render_done,
  output logic              busy,
  vertex_fetch_if.master    bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RDCNT = 2'd1,
    S_FETCH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_start_q;
  logic              r_read;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_ptr;
  logic [CNT_W-1:0]  r_n;
  logic [CNT_W-1:0]  r_widx;
  logic [1:0]        r_word;
  logic [31:0]       r_x;
  logic [31:0]       r_y;
  logic              r_done;

  logic [95:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [PTR_W:0]    r_count;

  logic              w_start_edge;
  logic              w_rvalid;
  logic              w_accept;
  logic              w_free;
  logic              w_push;
  logic              w_pop;
  logic              w_last;
  logic              w_space;
  logic [PTR_W:0]    w_count_nxt;
  logic [1:0]        w_word_nxt;
  logic [CNT_W-1:0]  w_count_rd;
  logic              w_issue;
  logic              w_issue_base;
  logic              w_done;

  assign w_start_edge = start && !r_start_q;
  // Data strobes arriving with nothing outstanding are dropped here.
  assign w_rvalid     = r_inflight && bus.m_readdatavalid;
  assign w_accept     = r_read && !bus.m_waitrequest;
  // The bus is free for a new request if nothing is pending after this cycle;
  // issuing in the data cycle keeps the rate at 2 cycles per word.
  assign w_free       = !r_read && (!r_inflight || bus.m_readdatavalid);
  assign w_push       = (r_state == S_FETCH) && w_rvalid && (r_word == 2'd2);
  assign w_pop        = (r_count != '0) && bus.vtx_ready;
  assign w_last       = (r_widx == (r_n - CNT_W'(1)));
  assign w_count_rd   = bus.m_readdata[CNT_W-1:0];
  assign w_word_nxt   = !w_rvalid ? r_word : ((r_word == 2'd2) ? 2'd0 : r_word + 2'd1);

  assign w_count_nxt  = r_count + (PTR_W+1)'(w_push) - (PTR_W+1)'(w_pop);
  // An x read reserves the FIFO slot its vertex will eventually occupy.
  assign w_space      = (w_count_nxt < (PTR_W+1)'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_issue_base = 1'b0;
    w_done       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_state_nxt  = S_RDCNT;
          w_issue      = 1'b1;
          w_issue_base = 1'b1;
        end
      end
      S_RDCNT: begin
        if (w_rvalid) begin
          if (w_count_rd == '0) begin
            w_state_nxt = S_DRAIN;
          end else begin
            w_state_nxt = S_FETCH;
            w_issue     = w_space;
          end
        end
      end
      S_FETCH: begin
        if (w_push && w_last) begin
          w_state_nxt = S_DRAIN;
        end else if (w_free && ((w_word_nxt != 2'd0) || w_space)) begin
          w_issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if ((r_count == '0) && !r_inflight && !r_read) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read master, address walk and vertex assembly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_start_q  <= 1'b0;
      r_read     <= 1'b0;
      r_inflight <= 1'b0;
      r_addr     <= '0;
      r_ptr      <= '0;
      r_n        <= '0;
      r_widx     <= '0;
      r_word     <= 2'd0;
      r_x        <= '0;
      r_y        <= '0;
      r_done     <= 1'b0;
    end else begin
      r_start_q <= start;
      r_done    <= w_done;

      if (w_issue) begin
        r_read <= 1'b1;
        if (w_issue_base) begin
          r_addr <= vertex_buffer_base;
          r_ptr  <= vertex_buffer_base + ADDR_W'(4);
        end else begin
          r_addr <= r_ptr;
          r_ptr  <= r_ptr + ADDR_W'(4);
        end
      end else if (w_accept) begin
        r_read <= 1'b0;
      end

      if (w_accept) begin
        r_inflight <= 1'b1;
      end else if (w_rvalid) begin
        r_inflight <= 1'b0;
      end

      if ((r_state == S_IDLE) && w_start_edge) begin
        r_widx <= '0;
        r_word <= 2'd0;
      end

      if ((r_state == S_RDCNT) && w_rvalid) begin
        r_n    <= w_count_rd;
        r_widx <= '0;
      end

      if ((r_state == S_FETCH) && w_rvalid) begin
        r_word <= w_word_nxt;
        if (r_word == 2'd0) r_x <= bus.m_readdata;
        if (r_word == 2'd1) r_y <= bus.m_readdata;
        if (w_push) r_widx <= r_widx + CNT_W'(1);
      end
    end
  end

  // Vertex FIFO; storage is reset so the head reads as zero when empty.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= {bus.m_readdata, r_y, r_x};
        r_wptr        <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  assign bus.m_read    = r_read;
  assign bus.m_address = r_addr;
  assign bus.vtx_valid = (r_count != '0);
  assign bus.vtx_data  = r_mem[r_rptr];
  assign render_done   = r_done;
  assign busy          = (r_state != S_IDLE) || r_done;

endmodule

// File: tb/tb_vertex_fetch.sv
module tb_vertex_fetch;
  localparam int ADDR_W = 26;
  localparam int DEPTH  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic [ADDR_W-1:0] base_in;
  logic              render_done;
  logic              busy;

  always #5 clk = ~clk;

  vertex_fetch_if #(.ADDR_W(ADDR_W)) bus ();

  vertex_fetch #(
    .ADDR_W(ADDR_W), .FIFO_DEPTH(DEPTH), .CNT_W(16)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .start(start),
    .vertex_buffer_base(base_in),
    .render_done(render_done),
    .busy(busy),
    .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [31:0]       mem [logic [ADDR_W-1:0]];
  int                wait_cfg   = 0;
  int                ready_mode = 0;
  bit                spurious   = 1'b0;

  logic [ADDR_W-1:0] rd_log [$];
  logic [95:0]       vx_log [$];
  int                done_cnt   = 0;
  int                viol_stall = 0;
  int                viol_head  = 0;
  int                viol_done  = 0;

  logic [ADDR_W-1:0] exp_addr [$];
  logic [95:0]       exp_vtx [$];
  int                rd0, vx0, dn0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Memory: fixed wait-state count per read, data one cycle after acceptance.
  initial begin : memory_model
    bit          pend = 1'b0;
    bit          stalling = 1'b0;
    int          wcnt = 0;
    logic [31:0] pdata = '0;
    bus.m_waitrequest   = 1'b0;
    bus.m_readdatavalid = 1'b0;
    bus.m_readdata      = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.m_readdatavalid = 1'b0;
      if (pend) begin
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = pdata;
        pend                = 1'b0;
      end else if (spurious) begin
        bus.m_readdatavalid = 1'b1;
        bus.m_readdata      = $urandom;
      end
      if (bus.m_read) begin
        if (!stalling) begin
          stalling = 1'b1;
          wcnt     = wait_cfg;
        end
        if (wcnt > 0) begin
          bus.m_waitrequest = 1'b1;
          wcnt--;
        end else begin
          bus.m_waitrequest = 1'b0;
          stalling          = 1'b0;
          pdata = mem.exists(bus.m_address) ? mem[bus.m_address]
                                            : (32'hdead_0000 ^ 32'(bus.m_address));
          pend  = 1'b1;
        end
      end else begin
        bus.m_waitrequest = 1'b0;
        stalling          = 1'b0;
      end
    end
  end

  initial begin : downstream
    bus.vtx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.vtx_ready = (ready_mode == 0) ? 1'b1 :
                      (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end
  end

  // Observers sample on the falling edge, half a cycle away from the DUT edge.
  logic              prev_stall = 1'b0;
  logic [ADDR_W-1:0] prev_addr  = '0;
  always @(negedge clk) begin
    if (bus.m_read && !bus.m_waitrequest) rd_log.push_back(bus.m_address);
    if (prev_stall && (!bus.m_read || bus.m_address !== prev_addr)) viol_stall++;
    prev_stall = reset_n && bus.m_read && bus.m_waitrequest;
    prev_addr  = bus.m_address;
  end

  logic        hv_prev = 1'b0;
  logic [95:0] hd_prev = '0;
  always @(negedge clk) begin
    if (bus.vtx_valid && bus.vtx_ready) vx_log.push_back(bus.vtx_data);
    if (hv_prev && (!bus.vtx_valid || bus.vtx_data !== hd_prev)) viol_head++;
    hv_prev = reset_n && bus.vtx_valid && !bus.vtx_ready;
    hd_prev = bus.vtx_data;
  end

  logic d_prev = 1'b0;
  always @(negedge clk) begin
    if (render_done) begin
      done_cnt++;
      if (!busy)  viol_done++;
      if (d_prev) viol_done++;
    end
    if (d_prev && busy) viol_done++;
    d_prev = render_done;
  end

  // Reference: word k of the frame lives at base+4k; vertex i = {w[3i+3],w[3i+2],w[3i+1]}.
  task automatic setup_frame(input logic [ADDR_W-1:0] base, input int n);
    logic [ADDR_W-1:0] a;
    logic [31:0]       w [$];
    exp_addr.delete();
    exp_vtx.delete();
    a = base;
    mem[a] = {16'($urandom), 16'(n)};
    exp_addr.push_back(a);
    for (int k = 1; k <= 3 * n; k++) begin
      a = base + ADDR_W'(4 * k);
      w.push_back($urandom);
      mem[a] = w[k-1];
      exp_addr.push_back(a);
    end
    for (int i = 0; i < n; i++) exp_vtx.push_back({w[3*i+2], w[3*i+1], w[3*i]});
  endtask

  task automatic kick(input logic [ADDR_W-1:0] base);
    @(posedge clk);
    #1;
    rd0     = rd_log.size();
    vx0     = vx_log.size();
    dn0     = done_cnt;
    base_in = base;
    start   = 1'b1;
  endtask

  task automatic drop_start();
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int c = 0;
    while (done_cnt == dn0 && c < 3000) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_done_seen"}, done_cnt != dn0, 1'b1);
  endtask

  task automatic check_frame(input string tag);
    repeat (3) @(negedge clk);
    check({tag, "_nreads"}, rd_log.size() - rd0, exp_addr.size());
    foreach (exp_addr[i])
      if (rd0 + i < rd_log.size()) check($sformatf("%s_addr%0d", tag, i), rd_log[rd0+i], exp_addr[i]);
    check({tag, "_nvtx"}, vx_log.size() - vx0, exp_vtx.size());
    foreach (exp_vtx[i])
      if (vx0 + i < vx_log.size()) check($sformatf("%s_vtx%0d", tag, i), vx_log[vx0+i], exp_vtx[i]);
    check({tag, "_done_pulses"}, done_cnt - dn0, 1);
    check({tag, "_busy_after"}, busy, 1'b0);
    check({tag, "_stall_stable"}, viol_stall, 0);
    check({tag, "_head_stable"}, viol_head, 0);
    check({tag, "_done_shape"}, viol_done, 0);
  endtask

  initial begin : main
    int c;
    reset_n = 1'b0;
    start   = 1'b0;
    base_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_read", bus.m_read, 1'b0);
    check("rst_m_address", bus.m_address, '0);
    check("rst_done", render_done, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_vtx_valid", bus.vtx_valid, 1'b0);
    check("rst_vtx_data", bus.vtx_data, '0);
    reset_n = 1'b1;

    // Data strobes while idle must not start anything.
    spurious = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    spurious = 1'b0;
    repeat (2) @(negedge clk);
    check("spur_m_read", bus.m_read, 1'b0);
    check("spur_busy", busy, 1'b0);
    check("spur_vtx_valid", bus.vtx_valid, 1'b0);

    // Empty buffer.
    setup_frame(26'h300000, 0);
    kick(26'h300000);
    drop_start();
    wait_done("t1");
    check_frame("t1");

    // Three vertices, zero wait states.
    setup_frame(26'h300000, 3);
    kick(26'h300000);
    drop_start();
    wait_done("t2");
    check_frame("t2");

    // Same buffer with 5 wait states per read.
    wait_cfg = 5;
    kick(26'h300000);
    drop_start();
    wait_done("t4");
    check_frame("t4");
    wait_cfg = 0;

    // Backpressure: FIFO fills with 8 vertices and fetching stops.
    setup_frame(26'h100000, 12);
    ready_mode = 1;
    kick(26'h100000);
    drop_start();
    repeat (200) @(negedge clk);
    check("t3_reads_full", rd_log.size() - rd0, 1 + 3 * DEPTH);
    check("t3_valid_full", bus.vtx_valid, 1'b1);
    check("t3_busy_full", busy, 1'b1);
    check("t3_no_pop", vx_log.size() - vx0, 0);
    repeat (50) @(negedge clk);
    check("t3_reads_hold", rd_log.size() - rd0, 1 + 3 * DEPTH);
    check("t3_m_read_low", bus.m_read, 1'b0);
    ready_mode = 0;
    wait_done("t3");
    check_frame("t3");

    // Reset in the middle of vertex 1.
    setup_frame(26'h200000, 3);
    kick(26'h200000);
    drop_start();
    c = 0;
    while (rd_log.size() - rd0 < 5 && c < 500) begin
      @(negedge clk);
      c++;
    end
    check("t5_reached_v1", rd_log.size() - rd0 >= 5, 1'b1);
    #1;
    reset_n = 1'b0;
    #1;
    check("t5_m_read", bus.m_read, 1'b0);
    check("t5_m_address", bus.m_address, '0);
    check("t5_busy", busy, 1'b0);
    check("t5_done", render_done, 1'b0);
    check("t5_vtx_valid", bus.vtx_valid, 1'b0);
    check("t5_vtx_data", bus.vtx_data, '0);
    repeat (3) @(negedge clk);
    #1;
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("t5_no_done", done_cnt - dn0, 0);
    check("t5_idle_busy", busy, 1'b0);
    kick(26'h200000);
    drop_start();
    wait_done("t5");
    check_frame("t5");

    // Start held across done; base input changes mid-frame.
    setup_frame(26'h000100, 2);
    kick(26'h000100);
    repeat (4) @(posedge clk);
    #1;
    base_in = 26'h3F0000;
    wait_done("t6a");
    check_frame("t6a");
    repeat (30) @(negedge clk);
    check("t6_no_restart_reads", rd_log.size() - rd0, exp_addr.size());
    check("t6_no_restart_busy", busy, 1'b0);
    check("t6_no_restart_done", done_cnt - dn0, 1);
    start = 1'b0;
    setup_frame(26'h3F0000, 1);
    kick(26'h3F0000);
    drop_start();
    wait_done("t6b");
    check_frame("t6b");

    // Randomized frames, first one wrapping past the top of the address space.
    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      logic [ADDR_W-1:0] b;
      int                n;
      b = (f == 0) ? 26'h3FFFFF8 : (ADDR_W'($urandom) & ~ADDR_W'(3));
      n = $urandom_range(1, 10);
      wait_cfg = $urandom_range(0, 3);
      setup_frame(b, n);
      kick(b);
      drop_start();
      wait_done($sformatf("r%0d", f));
      check_frame($sformatf("r%0d", f));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
